axi_master_port: RTL

- AXI4 initiator that turns simple command/data streams into AXI4 INCR read and write bursts on a 32-bit bus.
- It is the initiator end of the same AXI4 slave interface the GPU register and BRAM controller blocks respond on.
- Used by GPU-side logic (command fetch, status write-back) to read and write memory-mapped space.
- One outstanding transaction at a time; zero-bubble data passthrough once a burst is open.

---
 rtl/axi_pkg.sv | 12 +
 rtl/axi_master_port.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: AXI4 burst/size/response constants and the initiator FSM state type.
package axi_pkg;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE
  } master_state_t;
endpackage

// File: rtl/axi_master_port.sv
// axi_master_port: single-outstanding AXI4 INCR initiator bridging cmd/wr/rd streams to a 32-bit bus.
//   clock/reset : m_axi_aclk, m_axi_aresetn (synchronous, active-low)
//   cmd_*       : burst command (write flag, byte address, beats-1)
//   wr_* / rd_* : write-data sink and read-data source, passed through while a burst is open
//   done_*      : one-cycle completion pulse with worst response; proto_err is sticky rlast mismatch
//   M_AXI_*     : AXI4 AR/AW/W/B/R channels
module axi_master_port
  import axi_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter logic [3:0] AXCACHE = 4'b0011
) (
  input  logic              m_axi_aclk,
  input  logic              m_axi_aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_strb,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [31:0]       rd_data,
  output logic              rd_last,
  output logic              done_valid,
  output logic [1:0]        done_resp,
  output logic              proto_err,
  output logic [ADDR_W-1:0] M_AXI_araddr,
  output logic [7:0]        M_AXI_arlen,
  output logic [2:0]        M_AXI_arsize,
  output logic [1:0]        M_AXI_arburst,
  output logic [3:0]        M_AXI_arcache,
  output logic              M_AXI_arlock,
  output logic [2:0]        M_AXI_arprot,
  output logic              M_AXI_arvalid,
  input  logic              M_AXI_arready,
  output logic [ADDR_W-1:0] M_AXI_awaddr,
  output logic [7:0]        M_AXI_awlen,
  output logic [2:0]        M_AXI_awsize,
  output logic [1:0]        M_AXI_awburst,
  output logic [3:0]        M_AXI_awcache,
  output logic              M_AXI_awlock,
  output logic [2:0]        M_AXI_awprot,
  output logic              M_AXI_awvalid,
  input  logic              M_AXI_awready,
  output logic [31:0]       M_AXI_wdata,
  output logic [3:0]        M_AXI_wstrb,
  output logic              M_AXI_wlast,
  output logic              M_AXI_wvalid,
  input  logic              M_AXI_wready,
  input  logic [1:0]        M_AXI_bresp,
  input  logic              M_AXI_bvalid,
  output logic              M_AXI_bready,
  input  logic [31:0]       M_AXI_rdata,
  input  logic [1:0]        M_AXI_rresp,
  input  logic              M_AXI_rlast,
  input  logic              M_AXI_rvalid,
  output logic              M_AXI_rready
);
  master_state_t state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0] len_q, beat_cnt;
  logic [1:0] resp_acc;
  logic cmd_ready_q, accept, crosses_4k, last_beat, in_rd, in_wr, rd_fire, wr_fire;
  logic [10:0] end_word;
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{cmd_addr[1:0], addr_q[1:0]};
  // Word index of the final beat; bit 10 set means the burst runs past the 4 KB page.
  assign end_word   = {1'b0, cmd_addr[11:2]} + {3'b000, cmd_len};
  assign crosses_4k = end_word[10];
  assign accept     = cmd_valid && cmd_ready_q;
  assign last_beat  = beat_cnt == len_q;
  assign in_rd      = state == RD_DATA;
  assign in_wr      = state == WR_DATA;
  assign rd_fire    = in_rd && M_AXI_rvalid && rd_ready;
  assign wr_fire    = in_wr && wr_valid && M_AXI_wready;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = crosses_4k ? DONE : (cmd_write ? WR_ADDR : RD_ADDR);
      RD_ADDR: if (M_AXI_arready) state_n = RD_DATA;
      RD_DATA: if (rd_fire && last_beat) state_n = DONE;
      WR_ADDR: if (M_AXI_awready) state_n = WR_DATA;
      WR_DATA: if (wr_fire && last_beat) state_n = WR_RESP;
      WR_RESP: if (M_AXI_bvalid) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // cmd_ready is registered so it stays low on the first cycle out of reset.
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      beat_cnt    <= '0;
      resp_acc    <= AXI_RESP_OKAY;
      proto_err   <= 1'b0;
    end else begin
      state       <= state_n;
      cmd_ready_q <= state_n == IDLE;
      if (accept) begin
        addr_q   <= cmd_addr;
        len_q    <= cmd_len;
        beat_cnt <= '0;
        resp_acc <= crosses_4k ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
      if (rd_fire) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (M_AXI_rresp > resp_acc) resp_acc <= M_AXI_rresp;
        if (M_AXI_rlast != last_beat) proto_err <= 1'b1;
      end
      if (wr_fire) beat_cnt <= beat_cnt + 8'd1;
      if (state == WR_RESP && M_AXI_bvalid) resp_acc <= M_AXI_bresp;
    end
  end
  assign cmd_ready     = cmd_ready_q;
  assign M_AXI_araddr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign M_AXI_awaddr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign M_AXI_arlen   = len_q;
  assign M_AXI_awlen   = len_q;
  assign M_AXI_arsize  = AXI_SIZE_4B;
  assign M_AXI_awsize  = AXI_SIZE_4B;
  assign M_AXI_arburst = AXI_BURST_INCR;
  assign M_AXI_awburst = AXI_BURST_INCR;
  assign M_AXI_arcache = AXCACHE;
  assign M_AXI_awcache = AXCACHE;
  assign M_AXI_arlock  = 1'b0;
  assign M_AXI_awlock  = 1'b0;
  assign M_AXI_arprot  = 3'b000;
  assign M_AXI_awprot  = 3'b000;
  assign M_AXI_arvalid = state == RD_ADDR;
  assign M_AXI_awvalid = state == WR_ADDR;
  assign rd_valid      = in_rd && M_AXI_rvalid;
  assign M_AXI_rready  = in_rd && rd_ready;
  assign rd_data       = M_AXI_rdata;
  assign rd_last       = in_rd && last_beat;
  assign M_AXI_wvalid  = in_wr && wr_valid;
  assign wr_ready      = in_wr && M_AXI_wready;
  assign M_AXI_wdata   = wr_data;
  assign M_AXI_wstrb   = wr_strb;
  assign M_AXI_wlast   = in_wr && last_beat;
  assign M_AXI_bready  = state == WR_RESP;
  assign done_valid    = state == DONE;
  assign done_resp     = done_valid ? resp_acc : AXI_RESP_OKAY;
endmodule
